aes128_encrypt_ctrl: RTL and testbench
======================================

Name: aes128_encrypt_ctrl

Overview:
Iterative AES-128 encryption controller. Accepts one plaintext/key pair per valid/ready handshake and sequences one round per clock through the existing combinational round datapath: encrypt_round for rounds 1-9, encrypt_final_round for round 10. Round keys are generated on the fly, one per round. Holds the ciphertext until the consumer accepts it. Sits between the host/stream interface and the round datapath.

Parameters:
NR, 10, number of rounds; only 10 is supported.
EARLY_ACCEPT, 0, when 1 a new block may be accepted in the same cycle the current result is taken (back-to-back operation).

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  plaintext/key present
in_ready  out  1  controller can accept a block
plaintext  in  128  block; bits [127:120] are FIPS-197 byte 0
key  in  128  cipher key, same byte order
out_valid  out  1  ciphertext valid
out_ready  in  1  consumer accepts ciphertext
ciphertext  out  128  result, same byte order
busy  out  1  high in RUN
round_idx  out  4  current round, 0..10 (debug)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- State machine states: IDLE, RUN, DONE.
- Registers: state_reg[127:0], key_reg[127:0], round_reg[3:0].
- Reset values: state IDLE, out_valid=0, in_ready=1, busy=0, round_idx=0, ciphertext=0 (state_reg cleared).
- IDLE: in_ready=1. On in_valid&in_ready: state_reg<=plaintext^key (initial AddRoundKey), key_reg<=key, round_reg<=1, go to RUN.
- RUN: in_ready=0, busy=1.
  - Each cycle: k_next=key_step(key_reg, rcon[round_reg]); key_reg<=k_next.
  - state_reg<=encrypt_round(state_reg, k_next) when round_reg<10, else encrypt_final_round(state_reg, k_next).
  - round_reg<10: round_reg increments. round_reg==10: go to DONE.
  - in_valid is ignored in RUN.
- DONE: out_valid=1, ciphertext=state_reg, held stable until out_valid&out_ready.
  - On that handshake with EARLY_ACCEPT=0: go to IDLE.
  - EARLY_ACCEPT=1: in_ready=out_ready in DONE. If in_valid is also high, load the new block exactly as in IDLE and go straight to RUN. Otherwise go to IDLE.
- Latency: accept at cycle T -> out_valid at T+11.
- Throughput: 1 block per 12 cycles (EARLY_ACCEPT=0) or per 11 cycles (EARLY_ACCEPT=1, consumer always ready).
- ciphertext is driven from state_reg in all states; its value is only meaningful while out_valid=1.
- Reset mid-operation (RUN or DONE): block is discarded, no out_valid pulse, IDLE on the next cycle.
- round_idx = round_reg; it is 0 in IDLE.
- Datapath modules carry clk/reset ports; tie them to clk/reset. They add no latency.
- key_step: rotword + subword on word w3, xor with rcon, then chained xors w0..w3. It is purely combinational.
- rcon sequence, rounds 1..10: 01,02,04,08,10,20,40,80,1b,36.

Decomposition:
- Package aes128_pkg: NR=10, state enum (IDLE/RUN/DONE), rcon lookup function indexed 1..10.
- Sub-module aes128_key_step: combinational next-round-key, 4 S-box instances plus rcon xor.
- The controller instantiates aes128_key_step, encrypt_round and encrypt_final_round, and muxes between the two round outputs on round_reg==10.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a. out_valid rises exactly 11 cycles after accept.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32. round_idx steps 1..10 while busy=1.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> ciphertext and out_valid stable, in_ready=0 (EARLY_ACCEPT=0). Release -> IDLE next cycle, in_ready=1.
- in_valid held high through RUN -> second block is not accepted until after result handshake. Two results arrive in order.
- EARLY_ACCEPT=1 with out_ready=1 and in_valid=1 continuously, vectors C.1 then B -> results 11 cycles apart, both correct.
- Assert reset at RUN round 5 -> next cycle IDLE, out_valid=0, round_idx=0. A subsequent C.1 block yields the correct ct.

Source files
------------

// File: rtl/aes128_pkg.sv
// Shared AES-128 types, constants and byte-level helper functions.
package aes128_pkg;

  localparam int unsigned NR      = 10;
  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned ROUND_W = 4;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned WORD_W  = 32;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_e;

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Forward S-box lookup.
  function automatic byte_t sbox(input byte_t b);
    return SBOX[b];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // MixColumns on one column; row 0 sits in the top byte.
  function automatic word_t mix_column(input word_t w);
    byte_t a0, a1, a2, a3;
    byte_t b0, b1, b2, b3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  // Round constant for rounds 1..10; zero elsewhere.
  function automatic byte_t rcon(input logic [ROUND_W-1:0] r);
    byte_t rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes128_key_step.sv
// Combinational AES-128 key expansion step: previous round key -> next round key.
module aes128_key_step (
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] key_o
);
  import aes128_pkg::*;

  word_t w0, w1, w2, w3;
  word_t rot_w, sub_w, temp_w;
  word_t n0, n1, n2, n3;

  assign w0 = key_i[127:96];
  assign w1 = key_i[95:64];
  assign w2 = key_i[63:32];
  assign w3 = key_i[31:0];

  assign rot_w = {w3[23:0], w3[31:24]};

  // SubWord: one S-box per byte of the rotated word.
  for (genvar i = 0; i < 4; i++) begin : g_sub
    assign sub_w[31-8*i -: 8] = sbox(rot_w[31-8*i -: 8]);
  end

  assign temp_w = sub_w ^ {rcon_i, 24'h000000};

  assign n0 = w0 ^ temp_w;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/encrypt_final_round.sv
// Final AES round: SubBytes, ShiftRows, AddRoundKey (no MixColumns).
module encrypt_final_round (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] state_i,
  input  logic [127:0] round_key_i,
  output logic [127:0] state_o
);
  import aes128_pkg::*;

  logic [127:0] shifted;

  // SubBytes fused with ShiftRows.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int unsigned DST = r + 4*c;
      localparam int unsigned SRC = r + 4*((c + r) % 4);
      assign shifted[127-8*DST -: 8] = sbox(state_i[127-8*SRC -: 8]);
    end
  end

  assign state_o = shifted ^ round_key_i;

  // Clock and reset are carried for interface uniformity; the round is pure logic.
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, reset};

endmodule

// File: rtl/encrypt_round.sv
// One full AES round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
module encrypt_round (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] state_i,
  input  logic [127:0] round_key_i,
  output logic [127:0] state_o
);
  import aes128_pkg::*;

  logic [127:0] shifted;
  logic [127:0] mixed;

  // SubBytes fused with ShiftRows: byte (r,c) takes source byte (r,(c+r)%4).
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int unsigned DST = r + 4*c;
      localparam int unsigned SRC = r + 4*((c + r) % 4);
      assign shifted[127-8*DST -: 8] = sbox(state_i[127-8*SRC -: 8]);
    end
    assign mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
  end

  assign state_o = mixed ^ round_key_i;

  // Clock and reset are carried for interface uniformity; the round is pure logic.
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, reset};

endmodule

// File: rtl/aes128_encrypt_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock, on-the-fly key schedule.
module aes128_encrypt_ctrl #(
  parameter int unsigned NR           = 10,
  parameter bit          EARLY_ACCEPT = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy,
  output logic [3:0]   round_idx
);
  import aes128_pkg::*;

  ctrl_state_e state_q, state_d;

  logic [BLOCK_W-1:0] data_q;
  logic [BLOCK_W-1:0] key_q;
  logic [ROUND_W-1:0] round_q;

  logic [BLOCK_W-1:0] key_next;
  logic [BLOCK_W-1:0] round_out;
  logic [BLOCK_W-1:0] final_out;
  byte_t              rcon_cur;
  logic               last_round;
  logic               load;

  assign rcon_cur   = rcon(round_q);
  assign last_round = (round_q == ROUND_W'(NR));
  assign load       = in_valid && in_ready;

  aes128_key_step u_key_step (
    .key_i  (key_q),
    .rcon_i (rcon_cur),
    .key_o  (key_next)
  );

  encrypt_round u_round (
    .clk         (clk),
    .reset       (reset),
    .state_i     (data_q),
    .round_key_i (key_next),
    .state_o     (round_out)
  );

  encrypt_final_round u_final_round (
    .clk         (clk),
    .reset       (reset),
    .state_i     (data_q),
    .round_key_i (key_next),
    .state_o     (final_out)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (load) state_d = RUN;
      end
      RUN: begin
        if (last_round) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = load ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: in_ready = 1'b1;
      RUN:  busy     = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = EARLY_ACCEPT ? out_ready : 1'b0;
      end
      default: ;
    endcase
  end

  // Block, key and round registers: load with initial AddRoundKey, then one round per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      key_q   <= '0;
      round_q <= '0;
    end else if (load) begin
      data_q  <= plaintext ^ key;
      key_q   <= key;
      round_q <= ROUND_W'(1);
    end else if (state_q == RUN) begin
      key_q  <= key_next;
      data_q <= last_round ? final_out : round_out;
      if (!last_round) round_q <= round_q + ROUND_W'(1);
    end else if ((state_q == DONE) && out_ready) begin
      round_q <= '0;
    end
  end

  assign ciphertext = data_q;
  assign round_idx  = round_q;

endmodule

// File: tb/tb_aes128_encrypt_ctrl.sv
// Scoreboard bench for aes128_encrypt_ctrl: dut0 with EARLY_ACCEPT=0, dut1 with EARLY_ACCEPT=1.
module tb_aes128_encrypt_ctrl;

  typedef struct {
    logic [127:0] ct;
    int           acc;
  } exp_t;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam int LATENCY = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic         reset0, in_valid0, in_ready0, out_valid0, out_ready0, busy0;
  logic [127:0] pt0, key0, ciphertext0, exp0;
  logic [3:0]   round_idx0;
  logic         reset1, in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [127:0] pt1, key1, ciphertext1, exp1;
  logic [3:0]   round_idx1;

  exp_t q0[$];
  exp_t q1[$];
  int   hs0 = -1;
  int   hs1_a = -1, hs1_b = -1;
  int   rise0 = 0, rise1 = 0;
  logic vprev0 = 1'b0, vprev1 = 1'b0;

  aes128_encrypt_ctrl #(.NR(10), .EARLY_ACCEPT(1'b0)) dut0 (
    .clk(clk), .reset(reset0), .in_valid(in_valid0), .in_ready(in_ready0),
    .plaintext(pt0), .key(key0), .out_valid(out_valid0), .out_ready(out_ready0),
    .ciphertext(ciphertext0), .busy(busy0), .round_idx(round_idx0)
  );

  aes128_encrypt_ctrl #(.NR(10), .EARLY_ACCEPT(1'b1)) dut1 (
    .clk(clk), .reset(reset1), .in_valid(in_valid1), .in_ready(in_ready1),
    .plaintext(pt1), .key(key1), .out_valid(out_valid1), .out_ready(out_ready1),
    .ciphertext(ciphertext1), .busy(busy1), .round_idx(round_idx1)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Accept monitors: push the expected result when a block is taken.
  always @(negedge clk) begin
    if (!reset0 && in_valid0 && in_ready0) q0.push_back('{ct: exp0, acc: cyc});
    if (!reset1 && in_valid1 && in_ready1) q1.push_back('{ct: exp1, acc: cyc});
  end

  // Output monitor dut0.
  always @(negedge clk) begin : mon0
    exp_t e;
    if (out_valid0 && !vprev0) rise0 = cyc;
    vprev0 = out_valid0;
    if (!reset0 && out_valid0 && out_ready0) begin
      if (q0.size() == 0) begin
        chk("dut0_unexpected_result", 128'(1), 128'(0));
      end else begin
        e = q0.pop_front();
        chk("dut0_ciphertext", ciphertext0, e.ct);
        chk("dut0_latency", 128'(rise0 - e.acc), 128'(LATENCY));
        hs0 = cyc;
      end
    end
  end

  // Output monitor dut1.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (out_valid1 && !vprev1) rise1 = cyc;
    vprev1 = out_valid1;
    if (!reset1 && out_valid1 && out_ready1) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_result", 128'(1), 128'(0));
      end else begin
        e = q1.pop_front();
        chk("dut1_ciphertext", ciphertext1, e.ct);
        chk("dut1_latency", 128'(rise1 - e.acc), 128'(LATENCY));
        hs1_a = hs1_b;
        hs1_b = cyc;
      end
    end
  end

  task automatic drive(input int d, input logic [127:0] p, input logic [127:0] k, input logic [127:0] c);
    if (d == 0) begin
      pt0 = p; key0 = k; exp0 = c; in_valid0 = 1'b1;
    end else begin
      pt1 = p; key1 = k; exp1 = c; in_valid1 = 1'b1;
    end
  endtask

  task automatic wait_accept(input int d, output int t);
    bit seen;
    seen = 1'b0;
    t = -1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (d == 0 ? (in_valid0 && in_ready0) : (in_valid1 && in_ready1)) begin
        seen = 1'b1;
        t = cyc;
      end
    end
    if (!seen) chk("accept_timeout", 128'(0), 128'(1));
  endtask

  task automatic wait_drain(input int d);
    bit empty;
    empty = 1'b0;
    for (int i = 0; i < 200 && !empty; i++) begin
      @(negedge clk);
      empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
    end
    if (!empty) chk("drain_timeout", 128'(0), 128'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int  ta, tb, t1, t2, bad;
    bit  seen;
    reset0 = 1'b1; reset1 = 1'b1;
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    out_ready0 = 1'b1; out_ready1 = 1'b1;
    pt0 = '0; key0 = '0; exp0 = '0;
    pt1 = '0; key1 = '0; exp1 = '0;
    repeat (3) @(posedge clk);
    #1;
    reset0 = 1'b0; reset1 = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst0_flags", 128'({out_valid0, in_ready0, busy0, round_idx0}), 128'({1'b0, 1'b1, 1'b0, 4'd0}));
    chk("rst0_ciphertext", ciphertext0, 128'(0));
    chk("rst1_flags", 128'({out_valid1, in_ready1, busy1, round_idx1}), 128'({1'b0, 1'b1, 1'b0, 4'd0}));
    chk("rst1_ciphertext", ciphertext1, 128'(0));

    // FIPS-197 C.1 vector.
    @(posedge clk); #1;
    drive(0, C1_PT, C1_KEY, C1_CT);
    wait_accept(0, ta);
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    wait_drain(0);

    // FIPS-197 B vector with round index stepping.
    drive(0, B_PT, B_KEY, B_CT);
    wait_accept(0, ta);
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk("round_idx_step", 128'({busy0, round_idx0}), 128'({1'b1, 4'(i)}));
    end
    @(negedge clk);
    chk("done_flags", 128'({out_valid0, busy0, round_idx0}), 128'({1'b1, 1'b0, 4'd10}));
    wait_drain(0);

    // Backpressure: result held while consumer stalls.
    out_ready0 = 1'b0;
    drive(0, C1_PT, C1_KEY, C1_CT);
    wait_accept(0, ta);
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (out_valid0) seen = 1'b1;
    end
    chk("bp_valid_seen", 128'(seen), 128'(1));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_hold_ct", ciphertext0, C1_CT);
      chk("bp_hold_flags", 128'({out_valid0, in_ready0, busy0}), 128'({1'b1, 1'b0, 1'b0}));
    end
    @(posedge clk); #1;
    out_ready0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_idle", 128'({out_valid0, in_ready0, busy0, round_idx0}), 128'({1'b0, 1'b1, 1'b0, 4'd0}));
    @(posedge clk); #1;

    // in_valid held through RUN: second block waits for the result handshake.
    drive(0, C1_PT, C1_KEY, C1_CT);
    wait_accept(0, ta);
    @(posedge clk); #1;
    drive(0, B_PT, B_KEY, B_CT);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready0) bad++;
    end
    chk("held_no_ready_in_run", 128'(bad), 128'(0));
    wait_accept(0, tb);
    chk("held_accept_after_handshake", 128'(tb), 128'(hs0 + 1));
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    wait_drain(0);

    // Reset during round 5 discards the block.
    drive(0, C1_PT, C1_KEY, C1_CT);
    wait_accept(0, ta);
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (round_idx0 == 4'd5) seen = 1'b1;
    end
    chk("rst_round5_reached", 128'(seen), 128'(1));
    if (q0.size() > 0) q0.delete(q0.size() - 1);
    reset0 = 1'b1;
    @(posedge clk); #1;
    reset0 = 1'b0;
    @(negedge clk);
    chk("midrst_idle", 128'({out_valid0, in_ready0, busy0, round_idx0}), 128'({1'b0, 1'b1, 1'b0, 4'd0}));
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid0) bad++;
    end
    chk("midrst_no_valid", 128'(bad), 128'(0));
    @(posedge clk); #1;
    drive(0, C1_PT, C1_KEY, C1_CT);
    wait_accept(0, ta);
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    wait_drain(0);

    // Early accept, back-to-back C.1 then B.
    drive(1, C1_PT, C1_KEY, C1_CT);
    wait_accept(1, t1);
    @(posedge clk); #1;
    drive(1, B_PT, B_KEY, B_CT);
    wait_accept(1, t2);
    chk("ea_accept_spacing", 128'(t2 - t1), 128'(LATENCY));
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    wait_drain(1);
    chk("ea_result_spacing", 128'(hs1_b - hs1_a), 128'(LATENCY));

    chk("q0_empty", 128'(q0.size()), 128'(0));
    chk("q1_empty", 128'(q1.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
